ssp_frame_slave: RTL

- Upstream front-end for SSP_UART.
- Receives an external 4-wire SPI-style serial frame and oversamples it in the Clk domain.
- Decodes each frame into the parallel SSP register-access signals SSP_UART consumes: SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI.
- Serialises the returned SSP_DO back onto MISO.

---
 rtl/ssp_frame_pkg.sv | 6 +
 rtl/ssp_edge_sync.sv | 27 ++
 rtl/ssp_frame_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ssp_frame_pkg.sv
// ssp_frame_pkg: shared frame-decoder state encoding and frame geometry
package ssp_frame_pkg;
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
    localparam int FRAME_LEN = 16;
    localparam int HDR_LEN   = 4;
endpackage

// File: rtl/ssp_edge_sync.sv
// ssp_edge_sync: multi-flop synchroniser with rise/fall strobes on the synchronised level
module ssp_edge_sync #(
    parameter int   pDepth  = 2,
    parameter logic pRstVal = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [pDepth-1:0] r_sync;
    logic              r_q_d;
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_sync <= {pDepth{pRstVal}};
            r_q_d  <= pRstVal;
        end else begin
            r_sync <= {r_sync[pDepth-2:0], i_d};
            r_q_d  <= r_sync[pDepth-1];
        end
    end
    assign o_q    = r_sync[pDepth-1];
    assign o_rise = o_q & ~r_q_d;
    assign o_fall = ~o_q & r_q_d;
endmodule

// File: rtl/ssp_frame_slave.sv
// ssp_frame_slave: oversampled SPI frame slave decoding 16-bit frames into SSP register-access strobes
module ssp_frame_slave
    import ssp_frame_pkg::*;
#(
    parameter int pSyncDepth = 2,
    parameter int pAW        = 3,
    parameter int pDW        = 12
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           SPI_SSELn,
    input  logic           SPI_SCK,
    input  logic           SPI_MOSI,
    output logic           SPI_MISO,
    output logic           SPI_MISO_OE,
    output logic           SSP_SSEL,
    output logic           SSP_SCK,
    output logic [pAW-1:0] SSP_RA,
    output logic           SSP_WnR,
    output logic           SSP_En,
    output logic           SSP_EOC,
    output logic [pDW-1:0] SSP_DI,
    input  logic [pDW-1:0] SSP_DO,
    output logic           FrmErr
);
    localparam int L_FL = pAW + 1 + pDW;
    localparam int L_CW = $clog2(L_FL + 1);
    localparam logic [L_CW-1:0] C_FL   = L_CW'(L_FL);
    localparam logic [L_CW-1:0] C_LAST = L_CW'(L_FL - 1);
    localparam logic [L_CW-1:0] C_HL   = L_CW'(pAW + 1);

    logic w_sseln, w_sck, w_rise, w_fall, w_mosi;
    logic w_unused_ssel_rise, w_unused_ssel_fall, w_unused_mosi_rise, w_unused_mosi_fall;
    state_t r_state, w_nxt;
    logic [L_CW-1:0] r_cnt;
    logic [pDW-1:0]  r_rx, r_tx;
    logic            r_fall_d;
    logic w_start, w_shift, w_hdr_done, w_eoc, w_abort, w_exit;

    // SSELn idles high out of reset so the FSM never sees a phantom frame start
    ssp_edge_sync #(.pDepth(pSyncDepth), .pRstVal(1'b1)) u_ssel (
        .Clk(Clk), .Rst(Rst), .i_d(SPI_SSELn), .o_q(w_sseln),
        .o_rise(w_unused_ssel_rise), .o_fall(w_unused_ssel_fall));
    ssp_edge_sync #(.pDepth(pSyncDepth), .pRstVal(1'b0)) u_sck (
        .Clk(Clk), .Rst(Rst), .i_d(SPI_SCK), .o_q(w_sck),
        .o_rise(w_rise), .o_fall(w_fall));
    ssp_edge_sync #(.pDepth(pSyncDepth), .pRstVal(1'b0)) u_mosi (
        .Clk(Clk), .Rst(Rst), .i_d(SPI_MOSI), .o_q(w_mosi),
        .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

    assign SSP_SCK = w_sck;

    always_ff @(posedge Clk) begin
        if (!Rst) r_state <= IDLE;
        else      r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_start    = 1'b0;
        w_shift    = 1'b0;
        w_hdr_done = 1'b0;
        w_eoc      = 1'b0;
        w_abort    = 1'b0;
        w_exit     = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = ~w_sseln;
                w_nxt   = w_sseln ? IDLE : HDR;
            end
            HDR: begin
                w_abort    = w_sseln;
                w_hdr_done = ~w_sseln & (r_cnt == C_HL);
                w_shift    = ~w_sseln & (r_cnt != C_HL) & w_rise;
                w_nxt      = w_abort ? IDLE : (w_hdr_done ? DATA : HDR);
            end
            DATA: begin
                // a release coinciding with the final rise still completes the frame
                w_eoc   = (r_cnt == C_FL);
                w_abort = ~w_eoc & w_sseln & ~(w_rise & (r_cnt == C_LAST));
                w_shift = ~w_eoc & ~w_abort & w_rise;
                w_nxt   = w_eoc ? DONE : (w_abort ? IDLE : DATA);
            end
            DONE: begin
                w_exit = w_sseln;
                w_nxt  = w_sseln ? IDLE : DONE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_fall_d    <= 1'b0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            SSP_SSEL    <= 1'b0;
            SSP_RA      <= '0;
            SSP_WnR     <= 1'b0;
            SSP_En      <= 1'b0;
            SSP_EOC     <= 1'b0;
            SSP_DI      <= '0;
            FrmErr      <= 1'b0;
        end else begin
            r_fall_d <= w_fall;
            SSP_EOC  <= w_eoc;
            FrmErr   <= w_abort;
            if (w_start) begin
                r_cnt       <= '0;
                SSP_SSEL    <= 1'b1;
                SPI_MISO_OE <= 1'b1;
                SPI_MISO    <= 1'b0;
            end
            if (w_shift) begin
                r_rx  <= {r_rx[pDW-2:0], w_mosi};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_hdr_done) begin
                SSP_RA  <= r_rx[pAW:1];
                SSP_WnR <= r_rx[0];
                SSP_En  <= 1'b1;
                r_tx    <= SSP_DO;
            end
            if (w_eoc) begin
                SSP_DI <= r_rx;
                SSP_En <= 1'b0;
            end
            // delayed fall strobe keeps MISO latency aligned with the MOSI sample path
            if (r_state == DATA && r_fall_d) begin
                SPI_MISO <= r_tx[pDW-1];
                r_tx     <= {r_tx[pDW-2:0], 1'b0};
            end
            if (w_abort || w_exit) begin
                SSP_SSEL    <= 1'b0;
                SPI_MISO_OE <= 1'b0;
                SPI_MISO    <= 1'b0;
                SSP_En      <= 1'b0;
            end
        end
    end
endmodule
